// File: rtl/decode_imm_ctrl.sv
// decode_imm_ctrl: IF/ID controller with a 2-entry skid buffer, an immediate
// generator on the head entry, and a saturating counter of consumed illegal
// instructions.

// imm_Gen: classifies an instruction by opcode and builds its immediate.
// Formats R and illegal produce a zero immediate.
module imm_Gen (
  input  logic [31:0] inst,
  output logic [31:0] imm,
  output logic [2:0]  fmt
);

  // Opcode classification; malformed low bits force the illegal class
  always_comb begin
    fmt = 3'd7;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:0])
        7'b0110011: fmt = 3'd0;
        7'b0000011,
        7'b0010011,
        7'b1100111,
        7'b1110011: fmt = 3'd1;
        7'b0100011: fmt = 3'd2;
        7'b1100011: fmt = 3'd3;
        7'b0110111,
        7'b0010111: fmt = 3'd4;
        7'b1101111: fmt = 3'd5;
        default:    fmt = 3'd7;
      endcase
    end
  end

  // Immediate assembly per format, sign-extended from bit 31 where applicable
  always_comb begin
    imm = 32'd0;
    case (fmt)
      3'd1: imm = {{20{inst[31]}}, inst[31:20]};
      3'd2: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      3'd3: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      3'd4: imm = {inst[31:12], 12'd0};
      3'd5: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

endmodule

module decode_imm_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      if_inst,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             flush,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_inst,
  output logic [XLEN-1:0]  id_pc,
  output logic [31:0]      id_imm,
  output logic [2:0]       id_fmt,
  output logic             id_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            ready_en;
  logic            accept;
  logic            consume;
  logic            load_head_new;
  logic            load_head_skid;
  logic            load_skid;
  logic [31:0]     head_inst;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     skid_inst;
  logic [XLEN-1:0] skid_pc;

  // ready_en keeps if_ready low until the first clock edge after reset release
  assign if_ready   = ready_en && (state_q != FULL) && !flush;
  assign id_valid   = (state_q != EMPTY);
  assign accept     = if_valid && if_ready;
  assign consume    = id_valid && id_ready;
  assign id_inst    = head_inst;
  assign id_pc      = head_pc;
  assign id_illegal = id_valid && (id_fmt == 3'd7);

  imm_Gen imm_gen_i (
    .inst (head_inst),
    .imm  (id_imm),
    .fmt  (id_fmt)
  );

  // Enables acceptance one clock after reset is released
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  // State register tracking the number of buffered entries
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Next-state and buffer load control; flush overrides every transition
  always_comb begin
    state_d        = state_q;
    load_head_new  = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d       = HALF;
            load_head_new = 1'b1;
          end
        end
        HALF: begin
          if (accept && consume) begin
            load_head_new = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            state_d        = HALF;
            load_head_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Head and skid data registers; skid only moves to head when head leaves
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_inst <= 32'd0;
      head_pc   <= '0;
      skid_inst <= 32'd0;
      skid_pc   <= '0;
    end else begin
      if (load_head_new) begin
        head_inst <= if_inst;
        head_pc   <= if_pc;
      end else if (load_head_skid) begin
        head_inst <= skid_inst;
        head_pc   <= skid_pc;
      end
      if (load_skid) begin
        skid_inst <= if_inst;
        skid_pc   <= if_pc;
      end
    end
  end

  // Saturating count of illegal instructions actually consumed by execute
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_cnt <= '0;
    end else if (consume && id_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_imm_ctrl.sv
// Testbench for decode_imm_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_decode_imm_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             if_valid;
  logic             if_ready;
  logic [31:0]      if_inst;
  logic [XLEN-1:0]  if_pc;
  logic             flush;
  logic             id_valid;
  logic             id_ready;
  logic [31:0]      id_inst;
  logic [XLEN-1:0]  id_pc;
  logic [31:0]      id_imm;
  logic [2:0]       id_fmt;
  logic             id_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  decode_imm_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .id_imm      (id_imm),
    .id_fmt      (id_fmt),
    .id_illegal  (id_illegal),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t q[$];
  bit     m_ready;
  int     m_cnt;
  int     checks = 0;
  int     passes = 0;

  function automatic int modelFmt(input logic [31:0] inst);
    int f;
    f = 7;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:0])
        7'h33:                      f = 0;
        7'h03, 7'h13, 7'h67, 7'h73: f = 1;
        7'h23:                      f = 2;
        7'h63:                      f = 3;
        7'h37, 7'h17:               f = 4;
        7'h6F:                      f = 5;
        default:                    f = 7;
      endcase
    end
    return f;
  endfunction

  function automatic logic [31:0] modelImm(input logic [31:0] inst);
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    int v;
    v = 0;
    case (modelFmt(inst))
      1: begin s12 = inst[31:20]; v = s12; end
      2: begin s12 = {inst[31:25], inst[11:7]}; v = s12; end
      3: begin b13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; v = b13; end
      4: v = int'(inst[31:12]) * 4096;
      5: begin j21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}; v = j21; end
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  function automatic bit expIfReady();
    return m_ready && (q.size() < 2) && !flush && !reset;
  endfunction

  // Compares every DUT output against the model state
  task automatic checkOutput();
    checkVal("if_ready", {31'd0, if_ready}, {31'd0, expIfReady()});
    checkVal("id_valid", {31'd0, id_valid}, {31'd0, q.size() > 0});
    checkVal("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
    if (q.size() > 0) begin
      checkVal("id_inst", id_inst, q[0].inst);
      checkVal("id_pc", id_pc, q[0].pc);
      checkVal("id_imm", id_imm, modelImm(q[0].inst));
      checkVal("id_fmt", 32'(id_fmt), 32'(modelFmt(q[0].inst)));
      checkVal("id_illegal", {31'd0, id_illegal}, {31'd0, modelFmt(q[0].inst) == 7});
    end else begin
      checkVal("id_illegal", {31'd0, id_illegal}, 32'd0);
    end
  endtask

  task automatic advanceModel();
    bit acc;
    bit con;
    if (reset) begin
      q.delete();
      m_cnt   = 0;
      m_ready = 0;
    end else begin
      acc = if_valid && expIfReady();
      con = (q.size() > 0) && id_ready;
      if (con) begin
        if (modelFmt(q[0].inst) == 7 && m_cnt < CNT_MAX) m_cnt++;
        void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (acc) q.push_back('{inst: if_inst, pc: if_pc});
      m_ready = 1;
    end
  endtask

  // One cycle: drive at the falling edge, check shortly after, advance the model
  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] inst,
                               input logic [XLEN-1:0] pc, input logic rdy, input logic fl);
    @(negedge clk);
    reset    = r;
    if_valid = v;
    if_inst  = inst;
    if_pc    = pc;
    id_ready = rdy;
    flush    = fl;
    if (r) begin
      q.delete();
      m_cnt = 0;
    end
    #1;
    checkOutput();
    advanceModel();
  endtask

  function automatic logic [31:0] randInst();
    logic [6:0] ops [10];
    logic [31:0] w;
    ops = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    w = $urandom;
    if ($urandom_range(0, 5) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  localparam logic [31:0] ADDI  = 32'h00500093;
  localparam logic [31:0] LW    = 32'hFFF02083;
  localparam logic [31:0] ADDI2 = 32'h00A00113;
  localparam logic [31:0] ILL   = 32'h0000007F;

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_inst = 32'd0; if_pc = '0;
    flush = 1'b0; id_ready = 1'b0;
    q.delete(); m_cnt = 0; m_ready = 0;

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, ADDI, 32'h100, 0, 0);
    checkVal("rst_if_ready", {31'd0, if_ready}, 32'd0);
    checkVal("rst_id_valid", {31'd0, id_valid}, 32'd0);
    checkVal("rst_cnt", 32'(illegal_cnt), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkVal("rel_if_ready_pre_clk", {31'd0, if_ready}, 32'd0);

    // Scenario 1: addi accepted into an empty buffer
    applyStimulus(0, 1, ADDI, 32'h100, 1, 0);
    checkVal("s1_if_ready", {31'd0, if_ready}, 32'd1);
    // Scenario 2: addi at head and consumed, lw becomes head
    applyStimulus(0, 1, LW, 32'h104, 1, 0);
    checkVal("s1_id_valid", {31'd0, id_valid}, 32'd1);
    checkVal("s1_id_imm", id_imm, 32'h5);
    checkVal("s1_id_fmt", 32'(id_fmt), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkVal("s2_imm_c1", id_imm, 32'hFFFFFFFF);
    applyStimulus(0, 1, ADDI2, 32'h108, 0, 0);
    checkVal("s2_imm_c2", id_imm, 32'hFFFFFFFF);
    applyStimulus(0, 1, ILL, 32'h10C, 0, 0);
    checkVal("s2_imm_c3", id_imm, 32'hFFFFFFFF);
    checkVal("s2_full_if_ready", {31'd0, if_ready}, 32'd0);

    // Scenario 3: drain the full buffer in order
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkVal("s3_first", id_inst, LW);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkVal("s3_second", id_inst, ADDI2);
    checkVal("s3_second_pc", id_pc, 32'h108);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkVal("s3_empty_valid", {31'd0, id_valid}, 32'd0);
    checkVal("s3_empty_ready", {31'd0, if_ready}, 32'd1);

    // Scenario 4: flush a full buffer holding an illegal head
    applyStimulus(0, 1, ILL, 32'h200, 0, 0);
    applyStimulus(0, 1, ADDI, 32'h204, 0, 0);
    applyStimulus(0, 1, LW, 32'h208, 0, 1);
    checkVal("s4_flush_if_ready", {31'd0, if_ready}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkVal("s4_id_valid", {31'd0, id_valid}, 32'd0);
    checkVal("s4_if_ready", {31'd0, if_ready}, 32'd1);
    checkVal("s4_cnt", 32'(illegal_cnt), 32'd0);

    // Scenario 5: stream illegal words until the counter saturates
    for (int i = 0; i < 260; i++) begin
      applyStimulus(0, 1, ILL, 32'(i * 4), 1, 0);
      if (i == 20) begin
        checkVal("s5_fmt", 32'(id_fmt), 32'd7);
        checkVal("s5_cnt_mid", 32'(illegal_cnt), 32'd19);
      end
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkVal("s5_cnt_sat", 32'(illegal_cnt), 32'hFF);

    // Randomized traffic including flushes and mid-operation resets
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 3) != 0),
                    randInst(),
                    XLEN'($urandom),
                    ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
